// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin, packet-locking arbiter driving a shared 2:1 mux into a one-entry output stage
module mux2_arbiter #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_last,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_last,
   output logic              req1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy
);
   localparam int CW = $clog2(MAX_HOLD + 1);
   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
   state_t state, state_n, oth_state;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [1:0] mid, mid_n;
   logic rr_ptr, rr_n, sel_n;
   logic can_take, gx, cur_valid, cur_last, oth_valid, acc;
   logic [DATA_W-1:0] cur_data;

   assign can_take   = !out_valid || out_ready;
   assign req0_ready = (state == GRANT0) && can_take;
   assign req1_ready = (state == GRANT1) && can_take;
   assign gx         = (state == GRANT1);
   assign cur_valid  = gx ? req1_valid : req0_valid;
   assign cur_data   = gx ? req1_data  : req0_data;
   assign cur_last   = gx ? req1_last  : req0_last;
   assign oth_valid  = gx ? req0_valid : req1_valid;
   assign oth_state  = gx ? GRANT0 : GRANT1;
   assign acc        = (state != IDLE) && cur_valid && can_take;
   assign cnt_inc    = (cnt == CW'(MAX_HOLD)) ? cnt : cnt + 1'b1;
   assign busy       = (state != IDLE) || out_valid;

   // Grant decision: a mid-packet grant is held until its last beat or a forced rotation;
   // a grant sitting at a packet boundary with its requester gone is released.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rr_n    = rr_ptr;
      mid_n   = mid;
      if (state == IDLE) begin
         cnt_n = '0;
         if (req0_valid && (!req1_valid || !rr_ptr)) state_n = GRANT0;
         else if (req1_valid) state_n = GRANT1;
      end else if (acc) begin
         mid_n[gx] = !cur_last;
         cnt_n     = cnt_inc;
         if (cur_last) begin
            state_n = oth_valid ? oth_state : (cur_valid ? state : IDLE);
            rr_n    = !gx;
            cnt_n   = '0;
         end else if (cnt_inc == CW'(MAX_HOLD) && oth_valid) begin
            state_n = oth_state;
            rr_n    = !gx;
            cnt_n   = '0;
         end
      end else if (!cur_valid && !mid[gx]) begin
         state_n = oth_valid ? oth_state : IDLE;
         cnt_n   = '0;
      end
      sel_n = (state_n == GRANT1) ? 1'b1 : (state_n == GRANT0) ? 1'b0 : sel;
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         rr_ptr <= 1'b0;
         mid    <= '0;
         sel    <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         rr_ptr <= rr_n;
         mid    <= mid_n;
         sel    <= sel_n;
      end
   end

   // One-entry output stage: load on accept, drain on downstream handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (acc) begin
         out_valid <= 1'b1;
         out_data  <= cur_data;
         out_last  <= cur_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: table-driven cycle vectors plus queue-fed sequences for multi-cycle cases
module tb_mux2_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
   logic [7:0] req0_data, req1_data, out_data;
   logic out_valid, out_last, out_ready, sel, busy;

   mux2_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .sel(sel), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic v0; logic [7:0] d0; logic l0;
      logic v1; logic [7:0] d1; logic l1;
      logic ordy;
      logic r0, r1, ov; logic [7:0] od; logic ol, sl, bz;
   } vec_t;

   vec_t tbl [11];
   int errors = 0, checks = 0, cyc = 0;
   logic [8:0] q0[$], q1[$], rx[$], ex[$];
   int rxt[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive();
      req0_valid = q0.size() > 0;
      req0_data  = q0.size() > 0 ? q0[0][7:0] : 8'h00;
      req0_last  = q0.size() > 0 ? q0[0][8] : 1'b0;
      req1_valid = q1.size() > 0;
      req1_data  = q1.size() > 0 ? q1[0][7:0] : 8'h00;
      req1_last  = q1.size() > 0 ? q1[0][8] : 1'b0;
   endtask

   task automatic step();
      logic f0, f1;
      @(negedge clk);
      f0 = req0_valid && req0_ready;
      f1 = req1_valid && req1_ready;
      if (out_valid && out_ready) begin
         rx.push_back({out_last, out_data});
         rxt.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (f0) void'(q0.pop_front());
      if (f1) void'(q1.pop_front());
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q0.delete(); q1.delete(); rx.delete(); rxt.delete(); ex.delete();
      drive();
      out_ready = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   task automatic cmp_rx(string nm);
      chk({nm, " count"}, rx.size(), ex.size());
      for (int i = 0; i < ex.size() && i < rx.size(); i++)
         chk($sformatf("%s beat%0d", nm, i), {23'd0, rx[i]}, {23'd0, ex[i]});
   endtask

   initial begin
      //              v0    d0     l0    v1    d1     l1   rdy  | r0    r1    ov    od     ol    sel   busy
      tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b0};

      out_ready = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         @(posedge clk);
         #1;
         req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = tbl[i].l0;
         req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = tbl[i].l1;
         out_ready  = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("row%0d req0_ready", i), req0_ready, tbl[i].r0);
         chk($sformatf("row%0d req1_ready", i), req1_ready, tbl[i].r1);
         chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].ov);
         chk($sformatf("row%0d out_data", i), out_data, tbl[i].od);
         chk($sformatf("row%0d out_last", i), out_last, tbl[i].ol);
         chk($sformatf("row%0d sel", i), sel, tbl[i].sl);
         chk($sformatf("row%0d busy", i), busy, tbl[i].bz);
      end

      do_reset();
      q1 = '{9'h0F0, 9'h0F1, 9'h1F2};
      drive();
      repeat (3) step();
      #2;
      chk("pre-reset out_valid", out_valid, 1);
      chk("pre-reset sel", sel, 1);
      chk("pre-reset busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("async reset out_valid", out_valid, 0);
      chk("async reset sel", sel, 0);
      chk("async reset busy", busy, 0);
      q1.delete();
      drive();
      #2 rst = 1'b0;

      rx.delete(); rxt.delete();
      q0 = '{9'h0A0, 9'h1A1, 9'h0A2, 9'h1A3};
      q1 = '{9'h0B0, 9'h1B1, 9'h0B2, 9'h1B3};
      drive();
      repeat (14) step();
      ex = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A2, 9'h1A3, 9'h0B2, 9'h1B3};
      cmp_rx("rr");
      if (rxt.size() == 8) chk("rr no gaps", rxt[7] - rxt[0], 7);

      do_reset();
      q0 = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4, 9'h0C5, 9'h0C6, 9'h1C7};
      q1 = '{9'h0D0, 9'h1D1};
      drive();
      repeat (20) step();
      ex = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h0C3, 9'h0D0, 9'h1D1, 9'h0C4, 9'h0C5, 9'h0C6, 9'h1C7};
      cmp_rx("rotate");

      do_reset();
      q0 = '{9'h0E0, 9'h0E1, 9'h1E2};
      drive();
      for (int k = 0; k < 10 && !out_valid; k++) begin
         step();
         #2;
      end
      chk("bp first valid", out_valid, 1);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         #2;
         chk($sformatf("bp%0d out_data", k), out_data, 8'hE0);
         chk($sformatf("bp%0d out_valid", k), out_valid, 1);
         chk($sformatf("bp%0d req0_ready", k), req0_ready, 0);
      end
      out_ready = 1'b1;
      repeat (10) step();
      ex = '{9'h0E0, 9'h0E1, 9'h1E2};
      cmp_rx("bp");
      #2;
      chk("bp drained busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Shares one 2:1 output mux between two streaming requesters using valid/ready handshakes, round-robin arbitration and packet locking.
- Drives the mux select from its grant state.
- Registers the selected beat into a one-entry output stage that feeds the downstream consumer.
- Sits between the two input sources and the single shared output path of the tile.

Parameters:
DATA_W, 8, width of each data beat
MAX_HOLD, 4, beats a requester may send in one grant before it is forced to yield, when the other requester is waiting (>=1)

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
req0_valid  input  1  requester 0 has a beat
req0_data  input  DATA_W  requester 0 beat data
req0_last  input  1  beat is the final beat of the requester 0 packet
req0_ready  output  1  requester 0 beat accepted this cycle when valid&ready
req1_valid  input  1  requester 1 has a beat
req1_data  input  DATA_W  requester 1 beat data
req1_last  input  1  beat is the final beat of the requester 1 packet
req1_ready  output  1  requester 1 beat accepted this cycle when valid&ready
out_valid  output  1  output stage holds a beat
out_data  output  DATA_W  output beat data
out_last  output  1  output beat last flag
out_ready  input  1  downstream accepts the output beat when valid&ready
sel  output  1  mux select (registered): index of the current or most recent grant
busy  output  1  high when state!=IDLE or out_valid

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; out_valid, out_data, out_last, sel = 0.
  - Beat counter = 0; rr_ptr = 0 (requester 0 favoured first).
  - Any beat held in the output stage is discarded. The reset is not synchronised in this block.
- States are IDLE, GRANT0 and GRANT1.
- Output stage:
  - can_take = !out_valid | out_ready.
  - reqX_ready = (state==GRANTX) & can_take. This is combinational, and reqX_ready is 0 in IDLE.
- Accept: a beat is accepted on an edge where reqX_valid & reqX_ready for the granted X.
  - out_data and out_last load from the accepted beat, and out_valid is set.
  - If no beat is accepted and out_ready is high, out_valid clears.
- Latency: a beat accepted at edge N is presented at the output from N (registered) until its downstream handshake.
- Data stability: out_data and out_last hold constant while out_valid & !out_ready.
- IDLE:
  - If only one requester is valid, grant it.
  - If both are valid, grant rr_ptr.
  - The transition takes one cycle. sel updates on the same edge. The counter is 0.
  - Stay in IDLE if neither requester is valid.
- GRANTX: the counter increments on each accepted beat and saturates at MAX_HOLD. On an accepted beat:
  - last=1: release. The next state is the other requester if it is valid; else X if reqX_valid is still asserted (new packet); else IDLE. rr_ptr = other. The counter is cleared.
  - last=0, the counter reaches or already is at MAX_HOLD, and the other requester is valid: forced rotation to the other requester. rr_ptr = other. The counter is cleared. The remainder of X's packet resumes at its next grant.
  - Otherwise: stay in GRANTX.
- Valid drops mid-packet: if reqX_valid drops mid-packet, the grant stays held with no timeout. Downstream backpressure likewise stalls the grant, and the counter does not advance.
- Simultaneous events: the arbitration decision uses only the edge's sampled valids. A release and a new request at the same edge go directly GRANTX->GRANTY with no IDLE bubble.
- MAX_HOLD=1: every beat rotates when both requesters are valid.
- sel: updates only on grant changes and holds its last value in IDLE.

Test Plan:
- Reset sanity: assert rst mid-transfer while out_valid=1 -> out_valid, sel and busy go to 0 immediately (asynchronously), without waiting for a clock edge. After release the first grant goes to req0 when both requesters are valid.
- Single requester, out_ready=1: req1 sends 3 beats (0x11,0x22,0x33 last) -> one IDLE cycle then sel=1. Beats appear on out_data one per cycle, 1 cycle after acceptance. IDLE follows, busy=0 after the output drains.
- Both requesters always valid, 2-beat packets (MAX_HOLD=4), out_ready=1 -> output order is req0 pkt, req1 pkt, req0 pkt, with no idle cycle between packets.
- Forced rotation with MAX_HOLD=4: req0 sends an 8-beat packet while req1 is valid -> 4 req0 beats, then req1's packet, then the remaining 4 req0 beats. out_last=1 only on true last beats.
- Backpressure: out_ready=0 for 5 cycles with a beat held -> out_data stays constant, req_ready=0, and the counter is frozen. After release the output resumes with no beat lost or duplicated.
- Same-edge release and request: req0 last beat accepted while req1_valid rises that cycle -> the next cycle is GRANT1 (sel=1, req1_ready=1) with no IDLE cycle.
